// File: rtl/quad_enc_pkg.sv
// Quadrature decode encoding, decode result type and the shared counter arithmetic
// used by every encoder channel.
package quad_enc_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_UP,
    DEC_DOWN,
    DEC_ILLEGAL
  } dec_e;

  // {a,b} successor when rotating up: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] next_up(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      ST_00:   r = ST_10;
      ST_10:   r = ST_11;
      ST_11:   r = ST_01;
      default: r = ST_00;
    endcase
    return r;
  endfunction

  // Legacy 2-edge decode only counts transitions leaving 00 or 11.
  function automatic dec_e quad_decode(input logic [1:0] prev, input logic [1:0] cur,
                                       input logic x4);
    dec_e r;
    logic counts;
    counts = x4 || (prev == ST_00) || (prev == ST_11);
    r = DEC_NONE;
    if (prev == cur)
      r = DEC_NONE;
    else if ((prev ^ cur) == 2'b11)
      r = DEC_ILLEGAL;
    else if (cur == next_up(prev))
      r = counts ? DEC_UP : DEC_NONE;
    else
      r = counts ? DEC_DOWN : DEC_NONE;
    return r;
  endfunction

  function automatic logic [31:0] step_calc(input logic [31:0] v, input logic [31:0] step,
                                            input logic [31:0] maxv, input logic up,
                                            input logic sat);
    logic [31:0] r;
    if (up) begin
      if (sat && (v > maxv - step)) r = maxv;
      else                          r = (v + step) & maxv;
    end else begin
      if (sat && (v < step)) r = '0;
      else                   r = (v - step) & maxv;
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_array_if.sv
// Pin and result bundle of the encoder array; the array itself sits on the slave side.
interface quad_encoder_array_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       a;
  logic [CHANNELS-1:0]       b;
  logic [CHANNELS-1:0]       clear;
  logic [CHANNELS-1:0]       err_clear;
  logic [CHANNELS*WIDTH-1:0] value;
  logic [CHANNELS-1:0]       step_pulse;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       error;

  modport master (output a, b, clear, err_clear, input value, step_pulse, dir, error);
  modport slave  (input a, b, clear, err_clear, output value, step_pulse, dir, error);
endinterface

// File: rtl/quad_enc_channel.sv
// One encoder slice: pin synchroniser, per-input debounce, quadrature decode and
// the wrap/saturate step counter with sticky illegal-transition flag.
module quad_enc_channel
  import quad_enc_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] STEP       = WIDTH'(1),
  parameter int              SYNC_STAGES = 2,
  parameter int              DEBOUNCE    = 4,
  parameter int              SATURATE    = 1,
  parameter int              X4          = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             warm_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clear_i,
  input  logic             err_clear_i,
  output logic [WIDTH-1:0] value_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             error_o
);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [SYNC_STAGES-1:0] sa_q, sb_q;
  logic [1:0]             sync, filt, prev_q;
  logic [WIDTH-1:0]       value_q, value_nxt;
  logic                   step_q, dir_q, err_q;
  dec_e                   dec;

  assign sync = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      // Combinational bypass keeps latency at SYNC_STAGES+DEBOUNCE+1 for DEBOUNCE=0.
      assign filt = sync;
    end else begin : g_deb
      localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
      localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE - 1);

      logic [1:0]         filt_q, filt_d;
      logic [1:0][CW-1:0] cnt_q, cnt_d;

      always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
          if (sync[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_TC) begin
            filt_d[i] = sync[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        if (warm_i) begin
          filt_d = sync;
          cnt_d  = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          filt_q <= '0;
          cnt_q  <= '0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  always_comb begin
    dec = DEC_NONE;
    if (!warm_i) dec = quad_decode(prev_q, filt, X4 != 0);
    value_nxt = WIDTH'(step_calc(32'(value_q), 32'(STEP), 32'(MAX_VAL),
                                 dec == DEC_UP, SATURATE != 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      prev_q  <= '0;
      value_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sa_q   <= {sa_q[SYNC_STAGES-2:0], a_i};
      sb_q   <= {sb_q[SYNC_STAGES-2:0], b_i};
      // Track the value filt will hold next during warm-up so decode starts from equality.
      prev_q <= warm_i ? sync : filt;
      step_q <= 1'b0;
      if (clear_i) begin
        value_q <= '0;
      end else if (dec == DEC_UP || dec == DEC_DOWN) begin
        value_q <= value_nxt;
        step_q  <= 1'b1;
        dir_q   <= (dec == DEC_UP);
      end
      if (dec == DEC_ILLEGAL) err_q <= 1'b1;
      else if (err_clear_i)   err_q <= 1'b0;
    end
  end

  assign value_o = value_q;
  assign step_o  = step_q;
  assign dir_o   = dir_q;
  assign error_o = err_q;
endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder front end: shared post-reset warm-up timer plus
// CHANNELS independent decode slices packed onto the interface.
module quad_encoder_array
  import quad_enc_pkg::*;
#(
  parameter int               CHANNELS    = 3,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter int               SYNC_STAGES = 2,
  parameter int               DEBOUNCE    = 4,
  parameter int               SATURATE    = 1,
  parameter int               X4          = 1
) (
  input logic                clk,
  input logic                reset,
  quad_encoder_array_if.slave bus
);
  localparam int WARM = SYNC_STAGES + DEBOUNCE + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic [WW-1:0]             warm_cnt_q;
  logic                      warm;
  logic [CHANNELS*WIDTH-1:0] value_w;
  logic [CHANNELS-1:0]       step_w, dir_w, err_w;

  assign warm = (warm_cnt_q != WW'(WARM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    warm_cnt_q <= '0;
    else if (warm) warm_cnt_q <= warm_cnt_q + WW'(1);
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      quad_enc_channel #(
        .WIDTH      (WIDTH),
        .STEP       (STEP),
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE),
        .SATURATE   (SATURATE),
        .X4         (X4)
      ) u_ch (
        .clk        (clk),
        .rst_n      (reset),
        .warm_i     (warm),
        .a_i        (bus.a[g]),
        .b_i        (bus.b[g]),
        .clear_i    (bus.clear[g]),
        .err_clear_i(bus.err_clear[g]),
        .value_o    (value_w[g*WIDTH +: WIDTH]),
        .step_o     (step_w[g]),
        .dir_o      (dir_w[g]),
        .error_o    (err_w[g])
      );
    end
  endgenerate

  assign bus.value      = value_w;
  assign bus.step_pulse = step_w;
  assign bus.dir        = dir_w;
  assign bus.error      = err_w;
endmodule
